// File: rtl/halve_tokens_pkg.sv
// ============================================================================
// Module      : halve_tokens_pkg
// Description : Shared types, default sizing and width helper for the
//               doubled-token receive decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package halve_tokens_pkg;

    typedef enum logic {IDLE, ODD} pair_state_t;

    localparam int DEFAULT_MAX_TOKENS = 200;

    // Counter must hold 0 .. 2*max_tokens inclusive.
    function automatic int run_w(input int max_tokens);
        return $clog2(2 * max_tokens + 1);
    endfunction

endpackage : halve_tokens_pkg

`default_nettype wire

// File: rtl/halve_tokens_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear and an at-max
//               indication; clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 9,
    parameter int MAX   = 400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_max
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == c_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count  = r_count;
    assign o_at_max = w_at_max;

endmodule : sat_counter

`default_nettype wire

// File: rtl/halve_tokens.sv
// ============================================================================
// Module      : halve_tokens
// Description : Pairs '1' cycles of a doubled-token serial stream into single
//               token pulses; flags odd-length and over-long runs (sticky).
//               Optional macro HALVE_TOKENS_ERR_MASK_EN suppresses pulses once
//               either error flag is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halve_tokens
    import halve_tokens_pkg::*;
#(
    parameter int MAX_TOKENS = DEFAULT_MAX_TOKENS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b,
    output logic a,
    output logic odd_error,
    output logic overflow
);

    localparam int               RUN_W       = run_w(MAX_TOKENS);
    localparam logic [RUN_W-1:0] c_RUN_MAX   = RUN_W'(2 * MAX_TOKENS);
    localparam logic [0:0]       c_ST_IDLE   = 1'b0;
    localparam logic [0:0]       c_ST_ODD    = 1'b1;

    logic [0:0]       r_state;
    logic             r_a;
    logic             r_odd_error;
    logic             r_overflow;

    logic [RUN_W-1:0] w_run_len;
    logic             w_at_max;
    logic             w_pair_done;
    logic             w_odd_next;
    logic             w_ovf_next;
    logic             w_a_next;

    sat_counter #(
        .WIDTH (RUN_W),
        .MAX   (2 * MAX_TOKENS)
    ) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!b),
        .i_inc    (b),
        .o_count  (w_run_len),
        .o_at_max (w_at_max)
    );

    assign w_pair_done = (r_state == c_ST_ODD) && b;
    assign w_odd_next  = r_odd_error || ((r_state == c_ST_ODD) && !b);
    assign w_ovf_next  = r_overflow  || (b && w_at_max);

`ifdef HALVE_TOKENS_ERR_MASK_EN
    // Gate with next-state flags so the pulse is blocked in the assert cycle too.
    assign w_a_next = w_pair_done && !w_odd_next && !w_ovf_next;
`else
    assign w_a_next = w_pair_done;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_a         <= 1'b0;
            r_odd_error <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= b ? ~r_state : c_ST_IDLE;
            r_a         <= w_a_next;
            r_odd_error <= w_odd_next;
            r_overflow  <= w_ovf_next;
        end
    end

    // Below saturation the run parity always tracks the pairing state.
    a_run_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        (w_run_len <= c_RUN_MAX) && (w_at_max || ((r_state == c_ST_ODD) == w_run_len[0])));

    assign a         = r_a;
    assign odd_error = r_odd_error;
    assign overflow  = r_overflow;

endmodule : halve_tokens

`default_nettype wire

// File: tb/tb_halve_tokens.sv
// ============================================================================
// Module      : tb_halve_tokens
// Description : Directed self-checking bench for halve_tokens; honours
//               HALVE_TOKENS_ERR_MASK_EN when building expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_halve_tokens;
    import halve_tokens_pkg::*;

    localparam int c_MAX = DEFAULT_MAX_TOKENS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b = 1'b0;
    logic a;
    logic odd_error;
    logic overflow;

    int errors = 0;
    int checks = 0;

    halve_tokens #(.MAX_TOKENS(c_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b         (b),
        .a         (a),
        .odd_error (odd_error),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

`ifdef HALVE_TOKENS_ERR_MASK_EN
    localparam bit c_MASKED = 1'b1;
`else
    localparam bit c_MASKED = 1'b0;
`endif

    task automatic cyc(input logic v);
        b = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        b = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        b = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL reset_a got=%b exp=0", a); end
        checks++; if (odd_error !== 1'b0) begin errors++; $display("FAIL reset_odd got=%b exp=0", odd_error); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        @(posedge clk);
        #1;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL reset_a_hold got=%b exp=0", a); end
        b = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_known_seq();
        bit [0:25] seq;
        bit [0:25] exp;
        seq = 26'b11011011110111111001111110;
        exp = 26'b00100100101001010100010101;
        do_reset();
        for (int k = 0; k < 26; k++) begin
            b = seq[k];
            checks++;
            if (a !== exp[k]) begin errors++; $display("FAIL known_a cycle=%0d got=%b exp=%b", k, a, exp[k]); end
            @(posedge clk);
            #1;
        end
        checks++; if (odd_error !== 1'b0) begin errors++; $display("FAIL known_odd got=%b exp=0", odd_error); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL known_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_odd_run();
        do_reset();
        for (int k = 0; k < 54; k++) begin
            b = (k < 3);
            checks++;
            if (a !== (k == 2)) begin errors++; $display("FAIL odd_a cycle=%0d got=%b exp=%b", k, a, (k == 2)); end
            checks++;
            if (odd_error !== (k >= 4)) begin errors++; $display("FAIL odd_flag cycle=%0d got=%b exp=%b", k, odd_error, (k >= 4)); end
            @(posedge clk);
            #1;
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL odd_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_max_run();
        int   pulses;
        logic prev_a;
        pulses = 0;
        prev_a = 1'b0;
        do_reset();
        for (int k = 0; k < 405; k++) begin
            b = (k < 2 * c_MAX);
            if (a === 1'b1) pulses++;
            checks++;
            if (a === 1'b1 && prev_a === 1'b1) begin errors++; $display("FAIL max_back_to_back cycle=%0d got=11 exp=not11", k); end
            if (k == 2 * c_MAX) begin
                checks++;
                if (a !== 1'b1) begin errors++; $display("FAIL max_last_pulse got=%b exp=1", a); end
            end
            prev_a = a;
            @(posedge clk);
            #1;
        end
        checks++; if (pulses != c_MAX) begin errors++; $display("FAIL max_pulses got=%0d exp=%0d", pulses, c_MAX); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL max_ovf got=%b exp=0", overflow); end
        checks++; if (odd_error !== 1'b0) begin errors++; $display("FAIL max_odd got=%b exp=0", odd_error); end
    endtask

    task automatic test_overflow();
        int pulses;
        int exp_pulses;
        pulses = 0;
        exp_pulses = c_MASKED ? c_MAX : c_MAX + 1;
        do_reset();
        for (int k = 0; k < 407; k++) begin
            b = (k < 2 * c_MAX + 2);
            if (a === 1'b1) pulses++;
            checks++;
            if (overflow !== (k >= 2 * c_MAX + 1)) begin
                errors++;
                $display("FAIL ovf_flag cycle=%0d got=%b exp=%b", k, overflow, (k >= 2 * c_MAX + 1));
            end
            @(posedge clk);
            #1;
        end
        checks++; if (pulses != exp_pulses) begin errors++; $display("FAIL ovf_pulses got=%0d exp=%0d", pulses, exp_pulses); end
        checks++; if (odd_error !== 1'b0) begin errors++; $display("FAIL ovf_odd got=%b exp=0", odd_error); end
    endtask

    task automatic test_reset_mid_pair();
        do_reset();
        cyc(1'b1);
        cyc(1'b0);
        checks++; if (odd_error !== 1'b1) begin errors++; $display("FAIL midrst_pre_odd got=%b exp=1", odd_error); end
        cyc(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (odd_error !== 1'b0) begin errors++; $display("FAIL midrst_async_odd got=%b exp=0", odd_error); end
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL midrst_async_a got=%b exp=0", a); end
        b = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b = 1'b1;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL midrst_a0 got=%b exp=0", a); end
        @(posedge clk);
        #1;
        b = 1'b0;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL midrst_a1 got=%b exp=0", a); end
        checks++; if (odd_error !== 1'b0) begin errors++; $display("FAIL midrst_odd1 got=%b exp=0", odd_error); end
        @(posedge clk);
        #1;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL midrst_a2 got=%b exp=0", a); end
        checks++; if (odd_error !== 1'b1) begin errors++; $display("FAIL midrst_odd2 got=%b exp=1", odd_error); end
    endtask

    task automatic test_sticky();
        logic exp_a;
        do_reset();
        cyc(1'b1);
        cyc(1'b0);
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                b = (j < 2);
                exp_a = (j == 2) && !c_MASKED;
                checks++;
                if (a !== exp_a) begin errors++; $display("FAIL sticky_a blk=%0d pos=%0d got=%b exp=%b", r, j, a, exp_a); end
                checks++;
                if (odd_error !== 1'b1) begin errors++; $display("FAIL sticky_odd blk=%0d pos=%0d got=%b exp=1", r, j, odd_error); end
                @(posedge clk);
                #1;
            end
        end
        b = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (odd_error !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", odd_error); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_known_seq();
        test_odd_run();
        test_max_run();
        test_overflow();
        test_reset_mid_pair();
        test_sticky();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_halve_tokens

`default_nettype wire
